ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port data RAM (6-bit address, 16-bit word) between two requesters: port A, the CPU datapath, and port B, the program/data loader. Each request is a single-word read or write. The block arbitrates between the ports, registers the winner's command onto the RAM strobes, waits out the RAM read latency, and returns read data to the owning port. It sits between the CPU core and the RAM, replacing the CPU's direct ram_read/ram_write/ram_addr drive.

## Interface
- ADDR_W, 6, RAM word-address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4 (0 not supported)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a_req, b_req  in  1  port requests transaction; held high until matching gnt
- a_we, b_we  in  1  1 = write, 0 = read; stable while req high
- a_addr, b_addr  in  ADDR_W  word address; stable while req high
- a_wdata, b_wdata  in  DATA_W  write data; stable while req high
- a_gnt, b_gnt  out  1  one-cycle pulse: command accepted and issued to RAM
- a_rvalid, b_rvalid  out  1  one-cycle pulse: read data valid
- a_rdata, b_rdata  out  DATA_W  read data; held until the next read completes on that port
- ram_read, ram_write  out  1  RAM strobes; never both high
- ram_addr  out  ADDR_W  RAM address
- ram_data_out  out  DATA_W  RAM write data
- ram_data_in  in  DATA_W  RAM read data, valid RD_LAT cycles after the ram_read cycle

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, pick a winner. Register its we/addr/wdata into ram_* and the owner ID, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: exactly one of ram_read/ram_write is high. The winner's gnt pulses.
  - Write: go to IDLE.
  - Read: load the latency counter with RD_LAT-1 and go to WAIT. If RD_LAT=1, the counter is already 0.
- WAIT: decrement the counter. At 0, capture ram_data_in into the owner's rdata, pulse the owner's rvalid on the next cycle, and go to IDLE.
- Arbitration with RAM_ARB_RR_EN: round-robin. On a tie, grant the port not granted last. last_grant updates only on a grant.
- Arbitration without RAM_ARB_RR_EN: see Configuration.
- ram_addr and ram_data_out hold their last value outside ISSUE. Only the strobes qualify them.
- Ports in IDLE keep waiting; no request is dropped.
- A requester lowering req before its gnt is a protocol violation. The command captured in IDLE still completes; the bench flags the violation via assertion.
- Reset values: state=IDLE, all gnt/rvalid/ram_read/ram_write=0, ram_addr=0, ram_data_out=0, a_rdata=b_rdata=0, last_grant=B (so A wins the first tie).
- Reset mid-transaction aborts the transaction immediately. Strobes drop asynchronously, no rvalid is issued, and the requester must re-request.

## Timing
- Request first seen high in IDLE at cycle t: ram strobe and gnt at t+1.
- Write throughput: one write per 2 cycles.
- Read: ram_data_in sampled at cycle t+1+RD_LAT; rvalid/rdata at t+2+RD_LAT.
- The rvalid cycle is an IDLE cycle, so a new arbitration may occur in that same cycle.
- Read throughput: one read per RD_LAT+2 cycles.
- All outputs are registered. There is no combinational path from req to gnt or ram_*.

## Configuration
- RAM_ARB_RR_EN defined: two-way round-robin arbitration as above.
- RAM_ARB_RR_EN undefined: fixed priority, A always beats B. The last_grant register and round-robin picker are not built. B can starve under continuous A traffic, which is accepted for the loader-while-halted use case.

## Structure
- Shared package ram_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT)
  - port ID constants (PORT_A=0, PORT_B=1)
  - RD_LAT legality bound
- Sub-module ram_arb_pick: combinational 2-way picker. Inputs are the two reqs and last_grant; outputs are winner ID and valid. It is compiled in round-robin or fixed-priority form per RAM_ARB_RR_EN.

## Test plan
- A write only, addr=6'h05, wdata=16'hBEEF → ram_write and a_gnt at t+1, ram_addr=05, ram_data_out=BEEF, b_gnt never pulses.
- B read, addr=6'h10, RD_LAT=2, RAM returns 16'h1234 → b_gnt at t+1, b_rvalid at t+4 with b_rdata=1234, a_rdata stays 0.
- A and B request together continuously (round-robin build) → grants alternate A, B, A, B; last_grant=B after reset gives A first.
- Same stimulus, fixed-priority build → A granted every transaction and b_gnt never pulses while a_req stays high.
- reset asserted during WAIT of an A read → strobes and outputs return to reset values immediately. No a_rvalid is issued; the next request after release issues normally.
- Back-to-back: A read completes (rvalid) in the same cycle B's request is seen → B's strobe fires on the following cycle with no idle gap.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: state encoding, port IDs and
// the legal range of the RAM read latency.
package ram_arb_pkg;

  // Arbiter state encoding.
  typedef logic [1:0] ram_arb_state_t;
  localparam ram_arb_state_t S_IDLE  = 2'd0;
  localparam ram_arb_state_t S_ISSUE = 2'd1;
  localparam ram_arb_state_t S_WAIT  = 2'd2;

  // Requester IDs.
  localparam logic PORT_A = 1'b0;  // CPU datapath
  localparam logic PORT_B = 1'b1;  // program/data loader

  // RAM read latency bounds; the wait counter is sized for the maximum.
  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 4;
  localparam int unsigned RD_LAT_CNT_W = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM strobe/data bus.
// slave: the arbiter side; master: requesters plus the RAM model.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
);
  logic              a_req, b_req;
  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt;
  logic              a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              ram_read, ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_data_in,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output ram_read, ram_write, ram_addr, ram_data_out
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_data_in,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  ram_read, ram_write, ram_addr, ram_data_out
  );
endinterface

// File: rtl/ram_arb_pick.sv
// Combinational two-way request picker.
// RAM_ARB_RR_EN defined: round-robin, a tie goes to the port not granted last.
// RAM_ARB_RR_EN undefined: fixed priority, A always beats B.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_last_grant,
  output logic o_winner,
  output logic o_valid
);

  assign o_valid = i_a_req | i_b_req;

`ifdef RAM_ARB_RR_EN
  // Sole requester wins; on a tie the port not granted last wins.
  always_comb begin
    o_winner = PORT_A;
    if (i_a_req && i_b_req) begin
      o_winner = ~i_last_grant;
    end else if (i_b_req) begin
      o_winner = PORT_B;
    end
  end
`else
  // History is irrelevant with fixed priority.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  // A always wins whenever it is requesting.
  always_comb begin
    o_winner = i_a_req ? PORT_A : PORT_B;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (port A) and the loader
// (port B). IDLE picks a winner and registers its command onto the RAM
// strobes; ISSUE pulses gnt; WAIT rides out the read latency and returns the
// read word to the owning port. All outputs are registered.
// Build option: RAM_ARB_RR_EN selects round-robin instead of A-first priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("ram_arbiter: RD_LAT must lie in 1..4");
  end

  logic              w_valid, w_winner, w_last_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  ram_arb_state_t          r_state;
  logic [RD_LAT_CNT_W-1:0] r_cnt;
  logic                    r_owner;
  logic                    r_a_gnt, r_b_gnt, r_a_rvalid, r_b_rvalid;
  logic                    r_ram_read, r_ram_write;
  logic [ADDR_W-1:0]       r_ram_addr;
  logic [DATA_W-1:0]       r_ram_wdata, r_a_rdata, r_b_rdata;

`ifdef RAM_ARB_RR_EN
  logic r_last_grant;

  // Remember who won most recently; reset favours A on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= PORT_B;
    end else if (r_state == S_IDLE && w_valid) begin
      r_last_grant <= w_winner;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = PORT_B;
`endif

  ram_arb_pick u_pick (
    .i_a_req      (bus.a_req),
    .i_b_req      (bus.b_req),
    .i_last_grant (w_last_grant),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  assign w_sel_we    = (w_winner == PORT_B) ? bus.b_we    : bus.a_we;
  assign w_sel_addr  = (w_winner == PORT_B) ? bus.b_addr  : bus.a_addr;
  assign w_sel_wdata = (w_winner == PORT_B) ? bus.b_wdata : bus.a_wdata;

  // Arbitration FSM; gnt, rvalid and strobes are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= PORT_A;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_owner     <= w_winner;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_ram_read  <= ~w_sel_we;
            r_ram_write <= w_sel_we;
            r_a_gnt     <= (w_winner == PORT_A);
            r_b_gnt     <= (w_winner == PORT_B);
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_ram_read) begin
            r_cnt   <= RD_LAT_CNT_W'(RD_LAT - 1);
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner == PORT_B) begin
              r_b_rdata  <= bus.ram_data_in;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= bus.ram_data_in;
              r_a_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_gnt        = r_a_gnt;
  assign bus.b_gnt        = r_b_gnt;
  assign bus.a_rvalid     = r_a_rvalid;
  assign bus.b_rvalid     = r_b_rvalid;
  assign bus.a_rdata      = r_a_rdata;
  assign bus.b_rdata      = r_b_rdata;
  assign bus.ram_read     = r_ram_read;
  assign bus.ram_write    = r_ram_write;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_data_out = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with RD_LAT=2 against a transaction-level model:
// a grant schedule keyed by cycle number plus a reference memory.
// Honours RAM_ARB_RR_EN the same way the design does.
module tb_ram_arbiter;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int          NCYC   = 2048;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 977) ^ 16'hA5C3;
  endfunction

  // RAM: data appears RD_LAT cycles after the ram_read cycle, noise otherwise.
  logic [15:0] ram_mem [64];
  logic [15:0] rd_pipe [RD_LAT];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (bus.ram_write) begin
      ram_mem[bus.ram_addr] <= bus.ram_data_out;
    end
    rd_pipe[0] <= bus.ram_read ? ram_mem[bus.ram_addr] : 16'($urandom);
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.ram_data_in = rd_pipe[RD_LAT-1];

  a_one_strobe: assert property (@(posedge clk) disable iff (reset)
    !(bus.ram_read && bus.ram_write));
  a_hold_req_a: assert property (@(posedge clk) disable iff (reset)
    $fell(bus.a_req) |-> $past(bus.a_gnt));
  a_hold_req_b: assert property (@(posedge clk) disable iff (reset)
    $fell(bus.b_req) |-> $past(bus.b_gnt));

  // Expected events per cycle.
  bit          exp_gnt [2][NCYC];
  bit          exp_rv  [2][NCYC];
  bit          exp_rd  [NCYC];
  bit          exp_wr  [NCYC];
  logic [5:0]  exp_addr[NCYC];
  logic [15:0] exp_wd  [NCYC];
  logic [15:0] exp_rvd [NCYC];

  int          cyc, free_at, n_total, n_bad;
  logic [15:0] ref_mem [64];
  logic [5:0]  m_addr;
  logic [15:0] m_rdata [2];
`ifdef RAM_ARB_RR_EN
  int          m_last;
`endif

  bit          p_pend [2];
  bit          p_we   [2];
  logic [5:0]  p_addr [2];
  logic [15:0] p_wdata[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_bus();
    bus.a_req = p_pend[0]; bus.a_we = p_we[0]; bus.a_addr = p_addr[0]; bus.a_wdata = p_wdata[0];
    bus.b_req = p_pend[1]; bus.b_we = p_we[1]; bus.b_addr = p_addr[1]; bus.b_wdata = p_wdata[1];
  endtask

  task automatic set_req(input int p, input bit we, input logic [5:0] addr,
                         input logic [15:0] wdata);
    p_pend[p] = 1'b1; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
  endtask

  task automatic rand_req(input int p, input int pct);
    if (!p_pend[p] && $urandom_range(99) < pct)
      set_req(p, 1'($urandom_range(1)), 6'($urandom), 16'($urandom));
  endtask

  task automatic check_reset();
    check_eq("rst_a_gnt",    32'(bus.a_gnt),        32'h0);
    check_eq("rst_b_gnt",    32'(bus.b_gnt),        32'h0);
    check_eq("rst_a_rvalid", 32'(bus.a_rvalid),     32'h0);
    check_eq("rst_b_rvalid", 32'(bus.b_rvalid),     32'h0);
    check_eq("rst_ram_read", 32'(bus.ram_read),     32'h0);
    check_eq("rst_ram_wr",   32'(bus.ram_write),    32'h0);
    check_eq("rst_ram_addr", 32'(bus.ram_addr),     32'h0);
    check_eq("rst_ram_dout", 32'(bus.ram_data_out), 32'h0);
    check_eq("rst_a_rdata",  32'(bus.a_rdata),      32'h0);
    check_eq("rst_b_rdata",  32'(bus.b_rdata),      32'h0);
  endtask

  task automatic model_reset();
    for (int i = cyc; i < NCYC; i++) begin
      exp_gnt[0][i] = 1'b0; exp_gnt[1][i] = 1'b0;
      exp_rv[0][i]  = 1'b0; exp_rv[1][i]  = 1'b0;
      exp_rd[i]     = 1'b0; exp_wr[i]     = 1'b0;
    end
    free_at = 0;
`ifdef RAM_ARB_RR_EN
    m_last = 1;
`endif
    m_addr = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    p_pend[0] = 1'b0; p_pend[1] = 1'b0;
    drive_bus();
  endtask

  task automatic check_cycle();
    if (exp_rd[cyc] || exp_wr[cyc]) m_addr = exp_addr[cyc];
    for (int p = 0; p < 2; p++) if (exp_rv[p][cyc]) m_rdata[p] = exp_rvd[cyc];
    check_eq("a_gnt",     32'(bus.a_gnt),     32'(exp_gnt[0][cyc]));
    check_eq("b_gnt",     32'(bus.b_gnt),     32'(exp_gnt[1][cyc]));
    check_eq("ram_read",  32'(bus.ram_read),  32'(exp_rd[cyc]));
    check_eq("ram_write", 32'(bus.ram_write), 32'(exp_wr[cyc]));
    check_eq("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
    if (exp_wr[cyc]) check_eq("ram_data_out", 32'(bus.ram_data_out), 32'(exp_wd[cyc]));
    check_eq("a_rvalid",  32'(bus.a_rvalid),  32'(exp_rv[0][cyc]));
    check_eq("b_rvalid",  32'(bus.b_rvalid),  32'(exp_rv[1][cyc]));
    check_eq("a_rdata",   32'(bus.a_rdata),   32'(m_rdata[0]));
    check_eq("b_rdata",   32'(bus.b_rdata),   32'(m_rdata[1]));
  endtask

  // Move to the next cycle, check it, and retire requests granted last cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    for (int p = 0; p < 2; p++) if (exp_gnt[p][cyc-1]) p_pend[p] = 1'b0;
  endtask

  // Drive this cycle's requests; if the arbiter is free, schedule the outcome.
  task automatic decide();
    int w;
    int done_at;
    drive_bus();
    if (cyc < free_at || !(p_pend[0] || p_pend[1])) return;
`ifdef RAM_ARB_RR_EN
    if (p_pend[0] && p_pend[1]) w = (m_last == 1) ? 0 : 1;
    else                        w = p_pend[1] ? 1 : 0;
    m_last = w;
`else
    w = p_pend[0] ? 0 : 1;
`endif
    exp_gnt[w][cyc+1] = 1'b1;
    exp_addr[cyc+1]   = p_addr[w];
    if (p_we[w]) begin
      exp_wr[cyc+1] = 1'b1;
      exp_wd[cyc+1] = p_wdata[w];
      ref_mem[p_addr[w]] = p_wdata[w];
      free_at = cyc + 2;
    end else begin
      exp_rd[cyc+1] = 1'b1;
      done_at = cyc + 2 + int'(RD_LAT);
      exp_rv[w][done_at] = 1'b1;
      exp_rvd[done_at]   = ref_mem[p_addr[w]];
      free_at = done_at;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin advance(); decide(); end
  endtask

  initial begin
    cyc = 0; n_total = 0; n_bad = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; end
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    reset = 1'b0;

    // Single A write.
    advance(); set_req(0, 1'b1, 6'h05, 16'hBEEF); decide();
    advance();
    check_eq("wr_a_gnt", 32'(bus.a_gnt),        32'h1);
    check_eq("wr_addr",  32'(bus.ram_addr),     32'h05);
    check_eq("wr_data",  32'(bus.ram_data_out), 32'hBEEF);
    decide();
    idle_cycles(3);

    // Single B read; RAM holds 1234 at 0x10.
    advance(); set_req(1, 1'b0, 6'h10, 16'h0); decide();
    idle_cycles(int'(RD_LAT) + 1);
    advance();
    check_eq("rd_b_rvalid", 32'(bus.b_rvalid), 32'h1);
    check_eq("rd_b_rdata",  32'(bus.b_rdata),  32'h1234);
    check_eq("rd_a_rdata",  32'(bus.a_rdata),  32'h0);
    decide();
    idle_cycles(2);

    // Both ports requesting back to back.
    repeat (40) begin
      advance();
      for (int p = 0; p < 2; p++)
        if (!p_pend[p]) set_req(p, 1'($urandom_range(1)), 6'($urandom), 16'($urandom));
      decide();
    end
    idle_cycles(14);

    // A read finishing while B's request arrives in the rvalid cycle.
    advance(); set_req(0, 1'b0, 6'h03, 16'h0); decide();
    idle_cycles(int'(RD_LAT) + 1);
    advance();
    check_eq("b2b_a_rvalid", 32'(bus.a_rvalid), 32'h1);
    set_req(1, 1'b1, 6'h22, 16'hCAFE); decide();
    advance();
    check_eq("b2b_b_gnt", 32'(bus.b_gnt),     32'h1);
    check_eq("b2b_b_wr",  32'(bus.ram_write), 32'h1);
    decide();
    idle_cycles(4);

    // Reset while an A read sits in WAIT.
    advance(); set_req(0, 1'b0, 6'h05, 16'h0); decide();
    idle_cycles(2);
    #2;
    reset = 1'b1;
    #1;
    check_reset();
    model_reset();
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    reset = 1'b0;
    advance(); set_req(1, 1'b1, 6'h07, 16'h0F0F); decide();
    advance();
    check_eq("post_rst_b_gnt", 32'(bus.b_gnt), 32'h1);
    decide();
    idle_cycles(3);

    // Random traffic.
    repeat (800) begin
      advance();
      rand_req(0, 35);
      rand_req(1, 35);
      decide();
    end
    idle_cycles(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
